// File: rtl/tca9539_pkg.sv
// Shared definitions for the TCA9539 I/O-expander model: register map,
// register reset values and the I2C transaction state encoding.
package tca9539_pkg;

   // Command-byte register indices
   localparam logic [2:0] REG_IN0  = 3'd0;
   localparam logic [2:0] REG_IN1  = 3'd1;
   localparam logic [2:0] REG_OUT0 = 3'd2;
   localparam logic [2:0] REG_OUT1 = 3'd3;
   localparam logic [2:0] REG_POL0 = 3'd4;
   localparam logic [2:0] REG_POL1 = 3'd5;
   localparam logic [2:0] REG_CFG0 = 3'd6;
   localparam logic [2:0] REG_CFG1 = 3'd7;

   // Power-on values: outputs high, no inversion, all pins inputs
   localparam logic [7:0] RST_OUT = 8'hFF;
   localparam logic [7:0] RST_POL = 8'h00;
   localparam logic [7:0] RST_CFG = 8'hFF;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      CMD,
      CMD_ACK,
      WDATA,
      WDATA_ACK,
      RDATA,
      RDATA_ACK,
      IGNORE
   } state_t;

endpackage

// File: rtl/i2c_line_conditioner.sv
// Synchronises and glitch-filters SCL/SDA, then derives single-cycle
// SCL edge pulses and START/STOP bus conditions from the filtered levels.
module i2c_line_conditioner #(
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic scl,
   input  logic sda,
   output logic sda_level,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);

   localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

   // bit 0 = SCL, bit 1 = SDA
   logic [1:0] raw;
   logic [1:0] level;
   logic [1:0] level_prev;

   assign raw = {sda, scl};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_line
         logic [SYNC_STAGES-1:0] sync_reg;
         logic [CNT_W-1:0]       cnt_reg;
         logic                   level_reg;
         logic                   prev_reg;

         // Synchronise, then accept a new level only after FILTER_CYCLES equal samples
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               sync_reg  <= '1;
               cnt_reg   <= '0;
               level_reg <= 1'b1;
               prev_reg  <= 1'b1;
            end else begin
               sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw[gi]};
               prev_reg <= level_reg;
               if (sync_reg[SYNC_STAGES-1] != level_reg) begin
                  if (cnt_reg == CNT_LAST) begin
                     level_reg <= sync_reg[SYNC_STAGES-1];
                     cnt_reg   <= '0;
                  end else begin
                     cnt_reg <= cnt_reg + 1'b1;
                  end
               end else begin
                  cnt_reg <= '0;
               end
            end
         end

         assign level[gi]      = level_reg;
         assign level_prev[gi] = prev_reg;
      end
   endgenerate

   assign sda_level = level[1];
   assign scl_rise  =  level[0] & ~level_prev[0];
   assign scl_fall  = ~level[0] &  level_prev[0];
   // SDA edges while SCL is (and was) high are bus conditions, not data
   assign start_det = ~level[1] &  level_prev[1] & level[0] & level_prev[0];
   assign stop_det  =  level[1] & ~level_prev[1] & level[0] & level_prev[0];

endmodule

// File: rtl/i2c_slave_tca9539.sv
// TCA9539 I2C slave: decodes address/command/data bytes, holds the
// output, polarity and configuration registers, and serves reads.
module i2c_slave_tca9539
   import tca9539_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl,
   input  logic       sda_i,
   output logic       sda_o,
   output logic       sda_o_en,
   input  logic [6:0] deviceAddress,
   input  logic [7:0] input_port_0,
   input  logic [7:0] input_port_1,
   output logic [7:0] output_port_0,
   output logic [7:0] output_port_1,
   output logic [7:0] polarity_inversion_port_0,
   output logic [7:0] polarity_inversion_port_1,
   output logic [7:0] configuration_port_0,
   output logic [7:0] configuration_port_1
);

   logic sda_level, scl_rise, scl_fall, start_det, stop_det;

   state_t     state;
   logic [2:0] bit_cnt;
   logic [7:0] shift;
   logic [2:0] ptr;
   logic       ack_on;      // second half of a 9th-clock phase reached
   logic       rw;
   logic       master_ack;
   logic [7:0] regs [REG_OUT0:REG_CFG1];
   logic [7:0] rd_byte;

   i2c_line_conditioner #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES)
   ) u_cond (
      .clk       (clk),
      .rst       (rst),
      .scl       (scl),
      .sda       (sda_i),
      .sda_level (sda_level),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   assign sda_o = 1'b0;

   // Register selected by the command pointer; input ports are read live
   always_comb begin
      rd_byte = 8'h00;
      case (ptr)
         REG_IN0: rd_byte = input_port_0;
         REG_IN1: rd_byte = input_port_1;
         default: rd_byte = regs[ptr];
      endcase
   end

   // Transaction FSM, register writes and SDA drive (changed only after scl_fall)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         shift      <= '0;
         ptr        <= '0;
         ack_on     <= 1'b0;
         rw         <= 1'b0;
         master_ack <= 1'b0;
         sda_o_en   <= 1'b0;
         regs[REG_OUT0] <= RST_OUT;
         regs[REG_OUT1] <= RST_OUT;
         regs[REG_POL0] <= RST_POL;
         regs[REG_POL1] <= RST_POL;
         regs[REG_CFG0] <= RST_CFG;
         regs[REG_CFG1] <= RST_CFG;
      end else if (start_det) begin
         state    <= ADDR;
         bit_cnt  <= '0;
         ack_on   <= 1'b0;
         sda_o_en <= 1'b0;
      end else if (stop_det) begin
         state    <= IDLE;
         ack_on   <= 1'b0;
         sda_o_en <= 1'b0;
      end else begin
         unique case (state)
            ADDR: if (scl_rise) begin
               shift   <= {shift[6:0], sda_level};
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  ack_on <= 1'b0;
                  rw     <= sda_level;
                  state  <= (shift[6:0] == deviceAddress) ? ADDR_ACK : IGNORE;
               end
            end
            ADDR_ACK: if (scl_fall) begin
               if (!ack_on) begin
                  ack_on   <= 1'b1;
                  sda_o_en <= 1'b1;
               end else begin
                  ack_on <= 1'b0;
                  if (rw) begin
                     // Snapshot the byte now so it cannot change mid-transfer
                     shift    <= rd_byte;
                     sda_o_en <= ~rd_byte[7];
                     state    <= RDATA;
                  end else begin
                     sda_o_en <= 1'b0;
                     state    <= CMD;
                  end
               end
            end
            CMD: if (scl_rise) begin
               shift   <= {shift[6:0], sda_level};
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  ptr    <= {shift[1:0], sda_level};
                  ack_on <= 1'b0;
                  state  <= CMD_ACK;
               end
            end
            WDATA: if (scl_rise) begin
               shift   <= {shift[6:0], sda_level};
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  if (ptr >= REG_OUT0) begin
                     regs[ptr] <= {shift[6:0], sda_level};
                  end
                  ptr    <= ptr ^ 3'd1;
                  ack_on <= 1'b0;
                  state  <= WDATA_ACK;
               end
            end
            CMD_ACK, WDATA_ACK: if (scl_fall) begin
               if (!ack_on) begin
                  ack_on   <= 1'b1;
                  sda_o_en <= 1'b1;
               end else begin
                  ack_on   <= 1'b0;
                  sda_o_en <= 1'b0;
                  state    <= WDATA;
               end
            end
            RDATA: begin
               if (scl_fall) begin
                  // bit_cnt rises seen so far selects bit 7-bit_cnt
                  sda_o_en <= ~shift[~bit_cnt];
               end else if (scl_rise) begin
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     ack_on <= 1'b0;
                     state  <= RDATA_ACK;
                  end
               end
            end
            RDATA_ACK: begin
               if (scl_fall && !ack_on) begin
                  ack_on   <= 1'b1;
                  sda_o_en <= 1'b0;
               end else if (scl_rise && ack_on) begin
                  master_ack <= ~sda_level;
                  if (!sda_level) begin
                     ptr <= ptr ^ 3'd1;
                  end
               end else if (scl_fall && ack_on) begin
                  ack_on <= 1'b0;
                  if (master_ack) begin
                     shift    <= rd_byte;
                     sda_o_en <= ~rd_byte[7];
                     state    <= RDATA;
                  end else begin
                     state <= IGNORE;
                  end
               end
            end
            IDLE, IGNORE: ;
            default: state <= IDLE;
         endcase
      end
   end

   assign output_port_0             = regs[REG_OUT0];
   assign output_port_1             = regs[REG_OUT1];
   assign polarity_inversion_port_0 = regs[REG_POL0];
   assign polarity_inversion_port_1 = regs[REG_POL1];
   assign configuration_port_0      = regs[REG_CFG0];
   assign configuration_port_1      = regs[REG_CFG1];

endmodule

// File: tb/tb_i2c_slave_tca9539.sv
// Directed bench for the TCA9539 slave: an I2C master built from tasks,
// open-drain SDA modelled as a wired-AND, expected values written by hand.
module tb_i2c_slave_tca9539;

   localparam int Q = 20;   // clk cycles per quarter SCL period

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_bus;
   logic       sda_o, sda_o_en;
   logic [7:0] in0 = 8'h00, in1 = 8'h00;
   logic [7:0] out0, out1, pol0, pol1, cfg0, cfg1;
   int         checks = 0;
   int         failures = 0;
   int         en_cycles = 0;

   assign sda_bus = sda_m & ~sda_o_en;

   always #5 clk = ~clk;

   always @(posedge clk) if (sda_o_en) en_cycles++;

   i2c_slave_tca9539 dut (
      .clk                       (clk),
      .rst                       (rst),
      .scl                       (scl),
      .sda_i                     (sda_bus),
      .sda_o                     (sda_o),
      .sda_o_en                  (sda_o_en),
      .deviceAddress             (7'h74),
      .input_port_0              (in0),
      .input_port_1              (in1),
      .output_port_0             (out0),
      .output_port_1             (out1),
      .polarity_inversion_port_0 (pol0),
      .polarity_inversion_port_1 (pol1),
      .configuration_port_0      (cfg0),
      .configuration_port_1      (cfg1)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   task automatic qw();
      repeat (Q) @(negedge clk);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; qw();
      scl = 1'b1;   qw();
      sda_m = 1'b0; qw();
      scl = 1'b0;   qw();
   endtask

   task automatic i2c_stop(input string desc);
      sda_m = 1'b0; qw();
      scl = 1'b1;   qw();
      sda_m = 1'b1; qw();
      $display("txn %s done at %0t", desc, $time);
   endtask

   task automatic put_bit(input logic b);
      sda_m = b; qw();
      scl = 1'b1; qw(); qw();
      scl = 1'b0; qw();
   endtask

   task automatic get_ack(output logic a);
      sda_m = 1'b1; qw();
      scl = 1'b1; qw();
      a = ~sda_bus; qw();
      scl = 1'b0; qw();
   endtask

   task automatic write_byte(input logic [7:0] d, output logic a);
      for (int i = 7; i >= 0; i--) put_bit(d[i]);
      get_ack(a);
   endtask

   task automatic read_byte(output logic [7:0] d, input logic mack);
      for (int i = 7; i >= 0; i--) begin
         sda_m = 1'b1; qw();
         scl = 1'b1; qw();
         d[i] = sda_bus; qw();
         scl = 1'b0; qw();
      end
      put_bit(~mack);
      sda_m = 1'b1;
   endtask

   logic [7:0] d;
   logic       a;
   int         en_before;

   initial begin
      // ---- reset state ----
      repeat (5) @(negedge clk);
      check("rst_en", {7'd0, sda_o_en}, 8'h00);
      check("rst_out0", out0, 8'hFF);
      check("rst_out1", out1, 8'hFF);
      check("rst_pol0", pol0, 8'h00);
      check("rst_pol1", pol1, 8'h00);
      check("rst_cfg0", cfg0, 8'hFF);
      check("rst_cfg1", cfg1, 8'hFF);
      check("sda_o", {7'd0, sda_o}, 8'h00);
      rst = 1'b0;
      qw();

      // ---- read config registers 6/7 ----
      i2c_start();
      write_byte(8'hE8, a); check("cfg_addr_ack", {7'd0, a}, 8'h01);
      write_byte(8'h06, a); check("cfg_cmd_ack", {7'd0, a}, 8'h01);
      i2c_start();
      write_byte(8'hE9, a); check("cfg_raddr_ack", {7'd0, a}, 8'h01);
      read_byte(d, 1'b1);   check("rd_cfg0", d, 8'hFF);
      read_byte(d, 1'b0);   check("rd_cfg1", d, 8'hFF);
      i2c_stop("read cfg");

      // ---- write output ports, read back with pair toggle ----
      i2c_start();
      write_byte(8'hE8, a); check("wo_addr_ack", {7'd0, a}, 8'h01);
      write_byte(8'h02, a); check("wo_cmd_ack", {7'd0, a}, 8'h01);
      write_byte(8'h5A, a); check("wo_d0_ack", {7'd0, a}, 8'h01);
      write_byte(8'hA5, a); check("wo_d1_ack", {7'd0, a}, 8'h01);
      i2c_stop("write out");
      check("out0_5a", out0, 8'h5A);
      check("out1_a5", out1, 8'hA5);
      i2c_start();
      write_byte(8'hE8, a);
      write_byte(8'h02, a);
      i2c_start();
      write_byte(8'hE9, a); check("ro_addr_ack", {7'd0, a}, 8'h01);
      read_byte(d, 1'b1);   check("ro_b0", d, 8'h5A);
      read_byte(d, 1'b1);   check("ro_b1", d, 8'hA5);
      read_byte(d, 1'b0);   check("ro_b2", d, 8'h5A);
      i2c_stop("read out");

      // ---- input ports and discarded write ----
      in0 = 8'h3C; in1 = 8'hC3;
      i2c_start();
      write_byte(8'hE8, a);
      write_byte(8'h00, a);
      i2c_start();
      write_byte(8'hE9, a);
      read_byte(d, 1'b1);   check("rin_b0", d, 8'h3C);
      read_byte(d, 1'b0);   check("rin_b1", d, 8'hC3);
      i2c_stop("read in");
      i2c_start();
      write_byte(8'hE8, a);
      write_byte(8'h00, a);
      write_byte(8'h00, a); check("win_ack", {7'd0, a}, 8'h01);
      i2c_stop("write in");
      i2c_start();
      write_byte(8'hE8, a);
      write_byte(8'h00, a);
      i2c_start();
      write_byte(8'hE9, a);
      read_byte(d, 1'b0);   check("rin_after_w", d, 8'h3C);
      i2c_stop("reread in");
      check("out0_kept", out0, 8'h5A);

      // ---- wrong address: never driven, nothing written ----
      en_before = en_cycles;
      i2c_start();
      write_byte(8'hEA, a); check("bad_addr_nack", {7'd0, a}, 8'h00);
      write_byte(8'h02, a); check("bad_cmd_nack", {7'd0, a}, 8'h00);
      write_byte(8'h00, a); check("bad_data_nack", {7'd0, a}, 8'h00);
      i2c_stop("wrong addr");
      check("bad_no_drive", (en_cycles == en_before) ? 8'h01 : 8'h00, 8'h01);
      check("bad_out0", out0, 8'h5A);
      i2c_start();
      write_byte(8'hE8, a); check("good_addr_ack", {7'd0, a}, 8'h01);
      write_byte(8'h03, a);
      write_byte(8'h11, a);
      i2c_stop("write out1");
      check("out1_11", out1, 8'h11);

      // ---- polarity write then read without command, master NACK ----
      i2c_start();
      write_byte(8'hE8, a);
      write_byte(8'h05, a);
      write_byte(8'hFF, a);
      i2c_stop("write pol1");
      i2c_start();
      write_byte(8'hE8, a);
      write_byte(8'h04, a);
      write_byte(8'hFF, a);
      i2c_stop("write pol0");
      check("pol0_ff", pol0, 8'hFF);
      check("pol1_ff", pol1, 8'hFF);
      i2c_start();
      write_byte(8'hE9, a); check("nc_addr_ack", {7'd0, a}, 8'h01);
      read_byte(d, 1'b0);   check("nc_rd", d, 8'hFF);
      qw();
      check("nack_release", {7'd0, sda_o_en}, 8'h00);
      i2c_stop("read no cmd");
      check("stop_release", {7'd0, sda_o_en}, 8'h00);

      // ---- reset while the slave is driving ACK ----
      i2c_start();
      write_byte(8'hE8, a);
      for (int i = 7; i >= 0; i--) put_bit(1'b0);
      sda_m = 1'b1; qw();
      scl = 1'b1;   qw();
      check("pre_rst_ack", {7'd0, sda_o_en}, 8'h01);
      rst = 1'b1;
      #1;
      check("rst_async_en", {7'd0, sda_o_en}, 8'h00);
      check("rst_mid_out0", out0, 8'hFF);
      check("rst_mid_pol0", pol0, 8'h00);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      qw();
      scl = 1'b0; qw();
      i2c_stop("aborted by reset");
      i2c_start();
      write_byte(8'hE8, a); check("post_addr_ack", {7'd0, a}, 8'h01);
      write_byte(8'h02, a);
      write_byte(8'hC3, a); check("post_data_ack", {7'd0, a}, 8'h01);
      i2c_stop("post reset write");
      check("post_out0", out0, 8'hC3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
